// File: rtl/raster_pkg.sv
// Shared rasterizer memory constants and the port-ID type used to tag
// outstanding SDRAM reads.
package raster_pkg;

  localparam int ADDR_W        = 26;
  localparam int DATA_W        = 32;
  localparam int BE_W          = 4;
  localparam int NUM_MEM_PORTS = 3;

  typedef logic [1:0] port_id_t;

  localparam port_id_t PORT_VFETCH = 2'd0;
  localparam port_id_t PORT_DFETCH = 2'd1;
  localparam port_id_t PORT_ZTEST  = 2'd2;

endpackage

// File: rtl/raster_mem_arbiter_if.sv
// Avalon-MM bundle with NUM lanes packed side by side; NUM=1 is a plain
// single master/slave link.
interface raster_mem_arbiter_if #(
  parameter int NUM = 1
);

  logic [NUM*raster_pkg::ADDR_W-1:0] address;
  logic [NUM-1:0]                    read;
  logic [NUM-1:0]                    write;
  logic [NUM*raster_pkg::BE_W-1:0]   byteenable;
  logic [NUM*raster_pkg::DATA_W-1:0] writedata;
  logic [raster_pkg::DATA_W-1:0]     readdata;
  logic [NUM-1:0]                    readdatavalid;
  logic [NUM-1:0]                    waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/raster_mem_arbiter_id_fifo.sv
// Synchronous FIFO of port IDs, one entry per outstanding SDRAM read, so each
// return is steered to the master that issued it.
module raster_id_fifo
  import raster_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  port_id_t         push_id,
  input  logic             pop,
  output port_id_t         head_id,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  port_id_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
  assign do_push = push & (~full | do_pop);
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule

// File: rtl/raster_mem_arbiter.sv
// Round-robin merge of the rasterizer Avalon-MM masters onto one SDRAM port,
// with grant lock under waitrequest and in-order read-return routing.
module raster_mem_arbiter
  import raster_pkg::*;
#(
  parameter int NUM_PORTS   = NUM_MEM_PORTS,
  parameter int MAX_PENDING = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  raster_mem_arbiter_if.slave              s,
  raster_mem_arbiter_if.master             m,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending_cnt,
  output logic                             err_orphan
);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] eligible;
  logic                 gnt_vld;
  port_id_t             gnt_idx;
  logic                 lock_vld;
  port_id_t             lock_idx;
  port_id_t             rr_ptr;
  logic                 cmd_any;
  logic                 accept;
  logic                 fifo_full;
  logic                 fifo_empty;
  port_id_t             head_id;

  function automatic port_id_t wrap_add(input port_id_t base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return port_id_t'(sum);
  endfunction

  assign req      = s.read | s.write;
  assign eligible = req & ~(s.read & {NUM_PORTS{fifo_full}});

  // Scanning downward lets the nearest eligible port after rr_ptr win last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (lock_vld) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_idx;
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        if (eligible[wrap_add(rr_ptr, k)]) begin
          gnt_vld = 1'b1;
          gnt_idx = wrap_add(rr_ptr, k);
        end
      end
    end
  end

  always_comb begin
    m.address     = '0;
    m.read        = '0;
    m.write       = '0;
    m.byteenable  = '0;
    m.writedata   = '0;
    s.waitrequest = '1;
    if (gnt_vld && !reset) begin
      m.address[0 +: ADDR_W]    = s.address[gnt_idx*ADDR_W +: ADDR_W];
      m.read[0]                 = s.read[gnt_idx];
      m.write[0]                = s.write[gnt_idx] & ~s.read[gnt_idx];
      m.byteenable[0 +: BE_W]   = s.byteenable[gnt_idx*BE_W +: BE_W];
      m.writedata[0 +: DATA_W]  = s.writedata[gnt_idx*DATA_W +: DATA_W];
      s.waitrequest[gnt_idx]    = m.waitrequest[0];
    end
  end

  assign cmd_any = m.read[0] | m.write[0];
  assign accept  = gnt_vld & cmd_any & ~m.waitrequest[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_vld   <= 1'b0;
      lock_idx   <= '0;
      rr_ptr     <= '0;
      err_orphan <= 1'b0;
    end else begin
      lock_vld <= gnt_vld & cmd_any & m.waitrequest[0];
      if (gnt_vld) lock_idx <= gnt_idx;
      if (accept)  rr_ptr   <= wrap_add(gnt_idx, 1);
      if (m.readdatavalid[0] && fifo_empty) err_orphan <= 1'b1;
    end
  end

  raster_id_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_id_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (accept & m.read[0]),
    .push_id (gnt_idx),
    .pop     (m.readdatavalid[0]),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (pending_cnt)
  );

  assign s.readdata = m.readdata;

  always_comb begin
    s.readdatavalid = '0;
    if (!reset && m.readdatavalid[0] && !fifo_empty) s.readdatavalid[head_id] = 1'b1;
  end

endmodule

// File: tb/tb_raster_mem_arbiter.sv
// Bench for raster_mem_arbiter: vector table for arbitration, hand sequences
// for FIFO full/empty, orphan returns and reset, with a return-port scoreboard.
module tb_raster_mem_arbiter;
  import raster_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  raster_mem_arbiter_if #(.NUM(3)) s_bus ();
  raster_mem_arbiter_if #(.NUM(1)) m_bus ();
  logic [3:0] pending_cnt;
  logic       err_orphan;

  raster_mem_arbiter #(.NUM_PORTS(3), .MAX_PENDING(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .s           (s_bus),
    .m           (m_bus),
    .pending_cnt (pending_cnt),
    .err_orphan  (err_orphan)
  );

  localparam logic [25:0] ADDR_C [3] = '{26'h0000010, 26'h0000020, 26'h0000100};
  localparam logic [31:0] DATA_C [3] = '{32'h1111_0000, 32'h2222_0001, 32'hDEAD_BEEF};
  localparam logic [3:0]  BE_C   [3] = '{4'h1, 4'h3, 4'hF};

  int n_cmp  = 0;
  int n_fail = 0;
  port_id_t exp_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SDRAM model: 2-cycle read latency when auto_ret, plus manual strobes.
  logic        acc_n   = 1'b0;
  logic        rv1     = 1'b0;
  logic        rv2     = 1'b0;
  logic        auto_ret = 1'b1;
  logic        man_rv  = 1'b0;
  logic [31:0] rdata   = 32'h0;

  always @(negedge clock) acc_n = m_bus.read[0] & ~m_bus.waitrequest[0];
  always @(posedge clock) begin
    #1;
    rv2   = rv1;
    rv1   = acc_n;
    rdata = $urandom;
  end
  assign m_bus.readdatavalid = (auto_ret & rv2) | man_rv;
  assign m_bus.readdata      = rdata;

  always @(negedge clock) begin
    if (s_bus.readdatavalid !== 3'b000) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ret_unexpected: got readdatavalid %b expected none", s_bus.readdatavalid);
      end else begin
        port_id_t p;
        p = exp_q.pop_front();
        check("ret_port", s_bus.readdatavalid, 3'b001 << p);
        check("ret_data", s_bus.readdata, m_bus.readdata);
      end
    end
  end

  typedef struct {
    logic [2:0] rd;
    logic [2:0] wr;
    logic       wt;
    int         gnt;
  } vec_t;
  vec_t vecs [17];

  task automatic drive(input logic [2:0] rd, input logic [2:0] wr, input logic wt);
    s_bus.read         = rd;
    s_bus.write        = wr;
    m_bus.waitrequest  = wt;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic        e_rd, e_wr;
    logic [25:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [2:0]  e_ws;

    vecs[0]  = '{3'b000, 3'b100, 1'b0, 2};
    vecs[1]  = '{3'b000, 3'b110, 1'b0, 1};
    vecs[2]  = '{3'b000, 3'b101, 1'b0, 2};
    vecs[3]  = '{3'b111, 3'b000, 1'b0, 0};
    vecs[4]  = '{3'b111, 3'b000, 1'b0, 1};
    vecs[5]  = '{3'b111, 3'b000, 1'b0, 2};
    vecs[6]  = '{3'b111, 3'b000, 1'b0, 0};
    vecs[7]  = '{3'b111, 3'b000, 1'b0, 1};
    vecs[8]  = '{3'b111, 3'b000, 1'b0, 2};
    vecs[9]  = '{3'b000, 3'b001, 1'b0, 0};
    vecs[10] = '{3'b000, 3'b011, 1'b1, 1};
    vecs[11] = '{3'b000, 3'b011, 1'b1, 1};
    vecs[12] = '{3'b000, 3'b011, 1'b1, 1};
    vecs[13] = '{3'b000, 3'b011, 1'b0, 1};
    vecs[14] = '{3'b000, 3'b001, 1'b0, 0};
    vecs[15] = '{3'b100, 3'b100, 1'b0, 2};
    vecs[16] = '{3'b000, 3'b000, 1'b0, -1};

    s_bus.address    = {ADDR_C[2], ADDR_C[1], ADDR_C[0]};
    s_bus.writedata  = {DATA_C[2], DATA_C[1], DATA_C[0]};
    s_bus.byteenable = {BE_C[2], BE_C[1], BE_C[0]};
    reset = 1'b1;
    drive(3'b111, 3'b100, 1'b0);
    repeat (2) @(posedge clock);
    #3;
    check("rst_cmd", {m_bus.read[0], m_bus.write[0], s_bus.waitrequest, s_bus.readdatavalid},
          {1'b0, 1'b0, 3'b111, 3'b000});
    check("rst_state", {pending_cnt, err_orphan}, {4'd0, 1'b0});
    #6;
    reset = 1'b0;
    drive(3'b000, 3'b000, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].wt);
      #2;
      e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_be = '0; e_wd = '0; e_ws = 3'b111;
      if (vecs[i].gnt >= 0) begin
        e_rd   = vecs[i].rd[vecs[i].gnt];
        e_wr   = vecs[i].wr[vecs[i].gnt] & ~vecs[i].rd[vecs[i].gnt];
        e_addr = ADDR_C[vecs[i].gnt];
        e_be   = BE_C[vecs[i].gnt];
        e_wd   = DATA_C[vecs[i].gnt];
        e_ws[vecs[i].gnt] = vecs[i].wt;
      end
      check($sformatf("vec%0d", i),
            {m_bus.read[0], m_bus.write[0], m_bus.address, m_bus.byteenable, m_bus.writedata, s_bus.waitrequest},
            {e_rd, e_wr, e_addr, e_be, e_wd, e_ws});
      if (e_rd && !vecs[i].wt) exp_q.push_back(port_id_t'(vecs[i].gnt));
      next_cycle();
    end

    drive(3'b000, 3'b000, 1'b0);
    repeat (6) next_cycle();
    #2;
    check("drain_pending", pending_cnt, 4'd0);
    check("drain_queue", exp_q.size(), 0);

    // FIFO fill: port 0 reads with no returns, port 2 writes bypass.
    auto_ret = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(3'b001, 3'b000, 1'b0);
      #2;
      check($sformatf("fill%0d", i), pending_cnt, i);
      exp_q.push_back(PORT_VFETCH);
      next_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      drive(3'b001, 3'b100, 1'b0);
      #2;
      check($sformatf("full_wr%0d", i), {pending_cnt, m_bus.read[0], m_bus.write[0], s_bus.waitrequest},
            {4'd8, 1'b0, 1'b1, 3'b011});
      next_cycle();
    end
    man_rv = 1'b1;
    #2;
    check("full_pop", {pending_cnt, m_bus.read[0], s_bus.waitrequest[0]}, {4'd8, 1'b0, 1'b1});
    next_cycle();
    man_rv = 1'b0;
    drive(3'b001, 3'b000, 1'b0);
    #2;
    check("after_pop", {pending_cnt, m_bus.read[0], s_bus.waitrequest, m_bus.address},
          {4'd7, 1'b1, 3'b110, ADDR_C[0]});
    exp_q.push_back(PORT_VFETCH);
    next_cycle();
    drive(3'b000, 3'b000, 1'b0);
    #2;
    check("refull", pending_cnt, 4'd8);

    // Drain to 3, then push and pop together.
    man_rv = 1'b1;
    repeat (5) next_cycle();
    drive(3'b010, 3'b000, 1'b0);
    #2;
    check("pp_before", pending_cnt, 4'd3);
    exp_q.push_back(PORT_DFETCH);
    next_cycle();
    man_rv = 1'b0;
    drive(3'b000, 3'b000, 1'b0);
    #2;
    check("pp_after", pending_cnt, 4'd3);
    man_rv = 1'b1;
    repeat (3) next_cycle();
    #2;
    check("pp_drained", {pending_cnt, err_orphan}, {4'd0, 1'b0});
    check("orphan_no_rdv", s_bus.readdatavalid, 3'b000);
    next_cycle();
    man_rv = 1'b0;
    #2;
    check("orphan_set", err_orphan, 1'b1);

    // Reset with reads pending and a lock held.
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      drive(3'b001, 3'b000, 1'b0);
      exp_q.push_back(PORT_VFETCH);
      next_cycle();
    end
    drive(3'b000, 3'b010, 1'b1);
    #2;
    check("pre_rst", {pending_cnt, m_bus.write[0], m_bus.address}, {4'd4, 1'b1, ADDR_C[1]});
    next_cycle();
    reset  = 1'b1;
    man_rv = 1'b1;
    drive(3'b001, 3'b010, 1'b1);
    #2;
    check("in_rst", {m_bus.read[0], m_bus.write[0], s_bus.waitrequest, s_bus.readdatavalid},
          {1'b0, 1'b0, 3'b111, 3'b000});
    next_cycle();
    reset  = 1'b0;
    man_rv = 1'b0;
    exp_q.delete();
    #2;
    check("post_rst", {pending_cnt, err_orphan, m_bus.read[0], m_bus.write[0], m_bus.address},
          {4'd0, 1'b0, 1'b1, 1'b0, ADDR_C[0]});
    drive(3'b000, 3'b000, 1'b0);
    next_cycle();
    man_rv = 1'b1;
    #2;
    check("stray_no_rdv", s_bus.readdatavalid, 3'b000);
    next_cycle();
    man_rv = 1'b0;
    #2;
    check("stray_orphan", err_orphan, 1'b1);

    repeat (2) next_cycle();
    check("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
